// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard receiver: Hack special-key codes,
// scan-code prefixes and the frame FSM state type.
package ps2_pkg;
    localparam logic [15:0] KEY_NEWLINE   = 16'd128;
    localparam logic [15:0] KEY_BACKSPACE = 16'd129;
    localparam logic [15:0] KEY_LEFT      = 16'd130;
    localparam logic [15:0] KEY_UP        = 16'd131;
    localparam logic [15:0] KEY_RIGHT     = 16'd132;
    localparam logic [15:0] KEY_DOWN      = 16'd133;
    localparam logic [15:0] KEY_HOME      = 16'd134;
    localparam logic [15:0] KEY_END       = 16'd135;
    localparam logic [15:0] KEY_PAGE_UP   = 16'd136;
    localparam logic [15:0] KEY_PAGE_DOWN = 16'd137;
    localparam logic [15:0] KEY_INSERT    = 16'd138;
    localparam logic [15:0] KEY_DELETE    = 16'd139;
    localparam logic [15:0] KEY_ESC       = 16'd140;
    localparam logic [15:0] KEY_F1        = 16'd141;
    localparam logic [15:0] KEY_F2        = 16'd142;
    localparam logic [15:0] KEY_F3        = 16'd143;
    localparam logic [15:0] KEY_F4        = 16'd144;
    localparam logic [15:0] KEY_F5        = 16'd145;
    localparam logic [15:0] KEY_F6        = 16'd146;
    localparam logic [15:0] KEY_F7        = 16'd147;
    localparam logic [15:0] KEY_F8        = 16'd148;
    localparam logic [15:0] KEY_F9        = 16'd149;
    localparam logic [15:0] KEY_F10       = 16'd150;
    localparam logic [15:0] KEY_F11       = 16'd151;
    localparam logic [15:0] KEY_F12       = 16'd152;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_e;
endpackage

// File: rtl/ps2_keymap.sv
// Combinational scan-code set 2 to Hack key-code lookup; no shift handling.
// E0-prefixed navigation keys are only mapped when PS2_EXT_KEYS_EN is defined.
import ps2_pkg::*;

module ps2_keymap (
    input  logic        ext,
    input  logic [7:0]  scan,
    output logic        hit,
    output logic [15:0] code
);
    always_comb begin
        hit  = 1'b1;
        code = '0;
        if (!ext) begin
            case (scan)
                8'h1C: code = 16'd65;  8'h32: code = 16'd66;  8'h21: code = 16'd67;
                8'h23: code = 16'd68;  8'h24: code = 16'd69;  8'h2B: code = 16'd70;
                8'h34: code = 16'd71;  8'h33: code = 16'd72;  8'h43: code = 16'd73;
                8'h3B: code = 16'd74;  8'h42: code = 16'd75;  8'h4B: code = 16'd76;
                8'h3A: code = 16'd77;  8'h31: code = 16'd78;  8'h44: code = 16'd79;
                8'h4D: code = 16'd80;  8'h15: code = 16'd81;  8'h2D: code = 16'd82;
                8'h1B: code = 16'd83;  8'h2C: code = 16'd84;  8'h3C: code = 16'd85;
                8'h2A: code = 16'd86;  8'h1D: code = 16'd87;  8'h22: code = 16'd88;
                8'h35: code = 16'd89;  8'h1A: code = 16'd90;
                8'h45: code = 16'd48;  8'h16: code = 16'd49;  8'h1E: code = 16'd50;
                8'h26: code = 16'd51;  8'h25: code = 16'd52;  8'h2E: code = 16'd53;
                8'h36: code = 16'd54;  8'h3D: code = 16'd55;  8'h3E: code = 16'd56;
                8'h46: code = 16'd57;
                8'h29: code = 16'd32;
                8'h5A: code = KEY_NEWLINE;
                8'h66: code = KEY_BACKSPACE;
                8'h76: code = KEY_ESC;
                8'h05: code = KEY_F1;  8'h06: code = KEY_F2;  8'h04: code = KEY_F3;
                8'h0C: code = KEY_F4;  8'h03: code = KEY_F5;  8'h0B: code = KEY_F6;
                8'h83: code = KEY_F7;  8'h0A: code = KEY_F8;  8'h01: code = KEY_F9;
                8'h09: code = KEY_F10; 8'h78: code = KEY_F11; 8'h07: code = KEY_F12;
                default: hit = 1'b0;
            endcase
        end else begin
`ifdef PS2_EXT_KEYS_EN
            case (scan)
                8'h6B: code = KEY_LEFT;
                8'h75: code = KEY_UP;
                8'h74: code = KEY_RIGHT;
                8'h72: code = KEY_DOWN;
                8'h6C: code = KEY_HOME;
                8'h69: code = KEY_END;
                8'h7D: code = KEY_PAGE_UP;
                8'h7A: code = KEY_PAGE_DOWN;
                8'h70: code = KEY_INSERT;
                8'h71: code = KEY_DELETE;
                default: hit = 1'b0;
            endcase
`else
            hit = 1'b0;
`endif
        end
    end
endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: sync + glitch-filter pins, frame-check, track make/break, emit Hack key code
// one cycle after the stop-bit strobe. No backpressure. PS2_EXT_KEYS_EN enables E0 navigation keys.
import ps2_pkg::*;

module ps2_keyboard_rx #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key_code,
    output logic        key_valid,
    output logic        frame_err
);
    localparam int             FCW      = $clog2(FILTER_LEN + 1);
    localparam logic [FCW-1:0] FLT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [31:0]    TMO_CYC  = 32'(CLK_HZ / 1_000_000 * TIMEOUT_US);

    // Index 1 is the PS/2 clock, index 0 the PS/2 data line.
    logic [1:0]     raw, sync1, sync2, flt;
    logic [FCW-1:0] flt_cnt [2];
    logic           clk_prev, strobe, data_bit;

    assign raw = {ps2_clk, ps2_data};

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1    <= 2'b11;
            sync2    <= 2'b11;
            flt      <= 2'b11;
            clk_prev <= 1'b1;
            for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            clk_prev <= flt[1];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == flt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FLT_LAST) begin
                    flt[i]     <= sync2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + FCW'(1);
                end
            end
        end
    end

    assign strobe   = clk_prev & ~flt[1];
    assign data_bit = flt[0];

    frame_state_e state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   shreg_q, shreg_d;
    logic         par_q, par_d;
    logic [31:0]  tmo_q, tmo_d;
    logic         accept, err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        tmo_d     = '0;
        accept    = 1'b0;
        err       = 1'b0;
        if (state_q != IDLE) tmo_d = tmo_q + 32'd1;
        unique case (state_q)
            IDLE: if (strobe) begin
                if (!data_bit) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end else begin
                    err = 1'b1;
                end
            end
            DATA: if (strobe) begin
                shreg_d   = {data_bit, shreg_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: if (strobe) begin
                par_d   = data_bit;
                state_d = STOP;
            end
            STOP: if (strobe) begin
                state_d = IDLE;
                if (data_bit && (^{shreg_q, par_q})) accept = 1'b1;
                else                                 err    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // A strobe always restarts the inter-edge gap; otherwise a stalled frame is abandoned.
        if (strobe) begin
            tmo_d = '0;
        end else if (state_q != IDLE && tmo_q == TMO_CYC) begin
            state_d = IDLE;
            shreg_d = '0;
            tmo_d   = '0;
            err     = 1'b1;
        end
    end

    logic        brk_pending, ext_pending;
    logic        map_hit;
    logic [15:0] map_code;

    ps2_keymap u_keymap (
        .ext  (ext_pending),
        .scan (shreg_q),
        .hit  (map_hit),
        .code (map_code)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            key_code    <= '0;
            key_valid   <= 1'b0;
            frame_err   <= 1'b0;
            brk_pending <= 1'b0;
            ext_pending <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= err;
            if (err) begin
                brk_pending <= 1'b0;
                ext_pending <= 1'b0;
            end else if (accept) begin
                if (shreg_q == SC_BREAK) begin
                    brk_pending <= 1'b1;
                end else if (shreg_q == SC_EXT) begin
                    ext_pending <= 1'b1;
                end else begin
                    brk_pending <= 1'b0;
                    ext_pending <= 1'b0;
                    // Typematic repeats of the held key fall through without a pulse.
                    if (map_hit && !brk_pending && map_code != key_code) begin
                        key_code  <= map_code;
                        key_valid <= 1'b1;
                    end else if (map_hit && brk_pending && map_code == key_code) begin
                        key_code  <= '0;
                        key_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: bit-banged PS/2 frames, a scan-code-table model and a per-cycle compare.
module tb_ps2_keyboard_rx;
    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] key_code;
    logic        key_valid, frame_err;

    always #5 clk = ~clk;

    ps2_keyboard_rx #(.CLK_HZ(1_000_000), .FILTER_LEN(4), .TIMEOUT_US(200)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_code  (key_code),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    int  n_vec = 0, n_err = 0;
    int  kv_cnt = 0, fe_cnt = 0;
    bit  busy = 1'b1;
    logic [15:0] prev_code = '0;

    int  base_map [int];
    int  ext_map  [int];
    int  m_key = 0;
    bit  m_brk = 1'b0, m_ext = 1'b0;

    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] fkeys   [12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01,
                                 8'h09, 8'h78, 8'h07};
    logic [7:0] extkeys [10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};

`ifdef PS2_EXT_KEYS_EN
    localparam int EXP_UP = 131;
`else
    localparam int EXP_UP = 0;
`endif

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model whenever no frame is in flight.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            kv_cnt++;
            check("key_valid_without_change", int'(key_code != prev_code), 1);
        end
        if (frame_err === 1'b1) fe_cnt++;
        if (!busy) begin
            check("key_code_vs_model", key_code, m_key);
            check("key_valid_idle", key_valid, 0);
            check("frame_err_idle", frame_err, 0);
        end
        prev_code = key_code;
    end

    function automatic bit lookup(input bit ext, input int b, output int code);
        code = 0;
        if (ext && ext_map.exists(b)) begin
            code = ext_map[b];
            return 1'b1;
        end
        if (!ext && base_map.exists(b)) begin
            code = base_map[b];
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Applies one accepted byte to the model; returns the expected number of key_valid pulses.
    function automatic int model_byte(input logic [7:0] b);
        int code, old;
        bit hit;
        old = m_key;
        if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            hit = lookup(m_ext, int'(b), code);
            if (hit && !m_brk) m_key = code;
            else if (hit && m_brk && code == m_key) m_key = 0;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
        return (m_key != old) ? 1 : 0;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_edge(input logic b);
        ps2_data = b;
        wait_clk(HALF);
        ps2_clk = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
        int   kv0, fe0, kv_exp, fe_exp;
        logic par;
        busy = 1'b1;
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        par = ~^b;
        if (bad_par) par = ~par;
        ps2_edge(1'b0);
        for (int i = 0; i < 8; i++) ps2_edge(b[i]);
        ps2_edge(par);
        ps2_edge(bad_stop ? 1'b0 : 1'b1);
        ps2_data = 1'b1;
        if (!bad_par && !bad_stop) begin
            kv_exp = model_byte(b);
            fe_exp = 0;
        end else begin
            kv_exp = 0;
            fe_exp = 1;
            m_brk  = 1'b0;
            m_ext  = 1'b0;
        end
        wait_clk(10);
        check($sformatf("key_valid_pulses_%02h", b), kv_cnt - kv0, kv_exp);
        check($sformatf("frame_err_pulses_%02h", b), fe_cnt - fe0, fe_exp);
        busy = 1'b0;
    endtask

    task automatic bad_start();
        int kv0, fe0;
        busy = 1'b1;
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        ps2_edge(1'b1);
        m_brk = 1'b0;
        m_ext = 1'b0;
        wait_clk(10);
        check("bad_start_frame_err", fe_cnt - fe0, 1);
        check("bad_start_key_valid", kv_cnt - kv0, 0);
        busy = 1'b0;
    endtask

    task automatic stall_frame();
        int kv0, fe0;
        busy = 1'b1;
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        ps2_edge(1'b0);
        ps2_edge(1'b0); ps2_edge(1'b1); ps2_edge(1'b0); ps2_edge(1'b1);
        ps2_data = 1'b1;
        wait_clk(400);
        m_brk = 1'b0;
        m_ext = 1'b0;
        check("timeout_frame_err", fe_cnt - fe0, 1);
        check("timeout_key_valid", kv_cnt - kv0, 0);
        busy = 1'b0;
    endtask

    task automatic do_reset();
        busy = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        reset = 1'b0;
        wait_clk(3);
        check("reset_key_code", key_code, 0);
        check("reset_key_valid", key_valid, 0);
        check("reset_frame_err", frame_err, 0);
        reset = 1'b1;
        m_key = 0;
        m_brk = 1'b0;
        m_ext = 1'b0;
        wait_clk(2);
        busy = 1'b0;
    endtask

    task automatic lit(input string name, input int exp);
        check(name, key_code, exp);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int kv0;
        for (int i = 0; i < 26; i++) base_map[int'(letters[i])] = 65 + i;
        for (int i = 0; i < 10; i++) base_map[int'(digits[i])] = 48 + i;
        for (int i = 0; i < 12; i++) base_map[int'(fkeys[i])] = 141 + i;
        base_map[32'h29] = 32;
        base_map[32'h5A] = 128;
        base_map[32'h66] = 129;
        base_map[32'h76] = 140;
`ifdef PS2_EXT_KEYS_EN
        for (int i = 0; i < 10; i++) ext_map[int'(extkeys[i])] = 130 + i;
`endif

        do_reset();

        send_frame(8'h1C);                  lit("make_A", 65);
        send_frame(8'hF0); send_frame(8'h1C); lit("break_A", 0);

        kv0 = kv_cnt;
        send_frame(8'h1C); send_frame(8'h1C); send_frame(8'h1C);
        lit("typematic_A", 65);
        check("typematic_pulses", kv_cnt - kv0, 1);

        send_frame(8'hF0); send_frame(8'h32); lit("break_other_ignored", 65);
        send_frame(8'h32);                  lit("make_B_while_A", 66);
        send_frame(8'hF0); send_frame(8'h1C); lit("break_A_while_B", 66);
        send_frame(8'hF0); send_frame(8'h32); lit("break_B", 0);

        send_frame(8'hE0); send_frame(8'h75); lit("ext_up_make", EXP_UP);
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75); lit("ext_up_break", 0);
        send_frame(8'hE0); send_frame(8'h1C); lit("ext_unmapped", 0);

        send_frame(8'h29, 1'b1, 1'b0);      lit("bad_parity_space", 0);
        send_frame(8'h29, 1'b0, 1'b1);      lit("bad_stop_space", 0);
        send_frame(8'h29);                  lit("good_space", 32);
        send_frame(8'hF0); send_frame(8'h29); lit("break_space", 0);

        stall_frame();
        send_frame(8'h5A);                  lit("enter_after_timeout", 128);
        send_frame(8'hF0); send_frame(8'h5A); lit("break_enter", 0);

        send_frame(8'hF0); bad_start(); send_frame(8'h1C);
        lit("err_clears_break_flag", 65);
        send_frame(8'hF0); send_frame(8'h1C); lit("break_A_again", 0);

        send_frame(8'h45); lit("digit_0", 48);
        send_frame(8'h46); lit("digit_9", 57);
        send_frame(8'h07); lit("f12", 152);
        send_frame(8'h05); lit("f1", 141);
        send_frame(8'h76); lit("esc", 140);
        send_frame(8'h66); lit("backspace", 129);
        send_frame(8'h0E); lit("unmapped_make", 129);
        send_frame(8'hF0); send_frame(8'h66); lit("break_backspace", 0);

        busy = 1'b1;
        ps2_edge(1'b0); ps2_edge(1'b1); ps2_edge(1'b0);
        do_reset();
        send_frame(8'h1C);                  lit("make_after_midframe_reset", 65);

        send_frame(8'hF0);
        do_reset();
        send_frame(8'h1C);                  lit("make_after_prefix_reset", 65);

        send_frame(8'hF0); send_frame(8'hF0); send_frame(8'h1C); lit("double_break_prefix", 0);

        wait_clk(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

PS/2 keyboard receiver that converts raw device clock/data lines into the 16-bit Hack key code held in the memory-mapped keyboard register (word 24576). It sits between the board PS/2 pins and the CPU data-memory read mux, replacing direct PS/2-clocked capture with system-clock-domain sampling, frame checking, make/break tracking and scan-code translation.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency; used to derive the timeout.
- FILTER_LEN, 8, consecutive identical samples required before a filtered PS/2 line changes.
- TIMEOUT_US, 2000, maximum gap between falling edges inside one frame.

Ports:
- clk  in  1  system clock; every flop is on its rising edge.
- reset  in  1  synchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin; asynchronous.
- ps2_data  in  1  raw PS/2 data pin; asynchronous.
- key_code  out  16  Hack code of the key currently held; 0 when no key is held.
- key_valid  out  1  one-cycle pulse when key_code changes value.
- frame_err  out  1  one-cycle pulse on a rejected frame or a timeout.

## Operation
- Both pins pass through a 2-FF synchroniser, then a FILTER_LEN glitch filter. A falling edge of the filtered clock is a sample strobe.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a strobe with data=0 (start bit), go to DATA with bit_cnt=0. A start bit of 1 pulses frame_err and stays in IDLE.
  - DATA: shift the bit in LSB first; after the 8th bit go to PARITY.
  - PARITY: store the bit and go to STOP.
  - STOP: the frame is accepted when stop=1 and data+parity bits have odd parity. Otherwise pulse frame_err. Either way, return to IDLE.
- Timeout: a timeout counter runs in every non-IDLE state and is cleared on each strobe. When it reaches CLK_HZ/1_000_000*TIMEOUT_US, return to IDLE, discard the partial byte, and pulse frame_err.
- Byte decoder, applied to accepted bytes:
  - 0xF0 sets brk_pending.
  - 0xE0 sets ext_pending.
  - Any other byte is looked up as (ext_pending, byte), after which both flags are cleared.
- Make of a mapped key: key_code is set to the mapped code. Make of an unmapped code: no change.
- Typematic repeat of the held key: key_code is unchanged and there is no key_valid pulse.
- Break of the key whose code equals key_code: key_code is set to 0. Break of any other key is ignored.
- A frame error or timeout clears both flags.
- Mapping:
  - Letters 0x1C,0x32,0x21,0x23,0x24,0x2B.. map to uppercase ASCII 65..90.
  - Digits: 0x45 maps to 48; 0x16..0x46 map to 49..57.
  - Space 0x29 maps to 32; Enter 0x5A to 128; Backspace 0x66 to 129; Esc 0x76 to 140; F1..F12 to 141..152.
  - There is no shift handling.

## Timing
- Reset values: key_code=0, key_valid=0, frame_err=0, FSM=IDLE, flags cleared, filters preloaded to 1 (idle lines).
- Strobe latency: 2 + FILTER_LEN cycles after the raw falling edge.
- key_code and key_valid update in the same cycle, exactly 1 cycle after the stop-bit strobe.
- A reset asserted mid-frame or mid-prefix discards all state at the next clock edge.
- An 0xF0 received while brk_pending is already set is treated as a prefix again; the flag stays set.

## Configuration
- PS2_EXT_KEYS_EN defined: E0-prefixed codes are translated as follows.
  - 6B→130 (left), 75→131 (up), 74→132 (right), 72→133 (down).
  - 6C→134 (home), 69→135 (end), 7D→136 (page up), 7A→137 (page down).
  - 70→138 (insert), 71→139 (delete).
- PS2_EXT_KEYS_EN undefined: any byte following E0, including its F0 break sequence, is consumed with no change to key_code.

## Structure
- Shared package ps2_pkg holds:
  - Hack special-key constants (KEY_NEWLINE=128 .. KEY_F12=152).
  - Scan-code prefix constants (SC_BREAK=8'hF0, SC_EXT=8'hE0).
  - The FSM state enum.
- One sub-module, ps2_keymap: a purely combinational lookup from {ext, byte[7:0]} to {hit, code[15:0]}, instantiated once.

## Test plan
- Frame 0x1C (odd parity OK) -> key_code=65 and a 1-cycle key_valid; then F0,1C -> key_code=0 and key_valid pulses again.
- Frame 0x1C sent three times (typematic) -> key_code stays 65 with exactly one key_valid pulse.
- Hold 0x1C, send F0,32 -> key_code stays 65 and there is no pulse.
- With PS2_EXT_KEYS_EN: E0,75 -> 131; then E0,F0,75 -> 0. Without the macro: the same sequence leaves key_code=0 with no pulses.
- Frame with a bad parity bit, or stop=0, for 0x29 -> frame_err pulse and key_code unchanged; the next good 0x29 -> 32.
- Stop toggling ps2_clk after 4 data bits for longer than TIMEOUT_US -> frame_err pulse and FSM in IDLE; a following good 0x5A -> 128.
